// File: rtl/elevator_dispatch.sv
// Elevator dispatch controller: latches floor calls, selects the next stop with a
// SCAN sweep, tracks car position from step pulses and times the door.
module elevator_dispatch #(
    parameter int NUM_FLOORS   = 10,
    parameter int SECURE_FLOOR = 10,
    parameter int DOOR_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_request,
    input  logic                  secure,
    input  logic                  maintenance_request,
    input  logic                  floor_step,
    output logic [3:0]            current_floor,
    output logic                  move_up,
    output logic                  move_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  security_fault
);
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    localparam int            CW        = $clog2(DOOR_CYCLES + 1);
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES);
    localparam logic [3:0]    TOP_FLOOR = 4'(NUM_FLOORS);

    state_t                state, state_next;
    logic                  dir_up, dir_up_next;
    logic [3:0]            floor_next, floor_up, floor_down;
    logic [CW-1:0]         door_count, door_count_next;
    logic [NUM_FLOORS-1:0] pending_next, call_mask, here_mask;
    logic                  door_reload, fault_next;
    logic                  move_up_next, move_down_next, door_open_next;

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [3:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i + 1 == int'(f));
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [3:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i + 1 > int'(f));
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [3:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i + 1 < int'(f));
        return m;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            dir_up         <= 1'b1;
            current_floor  <= 4'd1;
            door_count     <= '0;
            pending        <= '0;
            move_up        <= 1'b0;
            move_down      <= 1'b0;
            door_open      <= 1'b0;
            security_fault <= 1'b0;
        end else begin
            state          <= state_next;
            dir_up         <= dir_up_next;
            current_floor  <= floor_next;
            door_count     <= door_count_next;
            pending        <= pending_next;
            move_up        <= move_up_next;
            move_down      <= move_down_next;
            door_open      <= door_open_next;
            security_fault <= fault_next;
        end
    end

    // A call for the floor whose door is open only extends the door time.
    always_comb begin
        here_mask   = floor_mask(current_floor);
        floor_up    = current_floor + 4'd1;
        floor_down  = current_floor - 4'd1;
        fault_next  = call_request[SECURE_FLOOR-1] & ~secure;
        door_reload = (state == DOOR) && (|(call_request & here_mask));
        call_mask   = call_request;
        if (!secure) call_mask[SECURE_FLOOR-1] = 1'b0;
        if (state == DOOR) call_mask = call_mask & ~here_mask;
    end

    always_comb begin
        state_next      = state;
        dir_up_next     = dir_up;
        floor_next      = current_floor;
        door_count_next = door_count;
        pending_next    = pending | call_mask;
        case (state)
            IDLE: begin
                if (|(pending & here_mask)) begin
                    state_next      = DOOR;
                    pending_next    = pending_next & ~here_mask;
                    door_count_next = DOOR_LOAD;
                end else if (!maintenance_request) begin
                    if ((|(pending & above_mask(current_floor))) &&
                        (dir_up || !(|(pending & below_mask(current_floor))))) begin
                        state_next  = MOVE_UP;
                        dir_up_next = 1'b1;
                    end else if (|(pending & below_mask(current_floor))) begin
                        state_next  = MOVE_DOWN;
                        dir_up_next = 1'b0;
                    end
                end
            end
            MOVE_UP: begin
                if (floor_step && current_floor < TOP_FLOOR) begin
                    floor_next = floor_up;
                    if (|(pending & floor_mask(floor_up))) begin
                        state_next      = DOOR;
                        pending_next    = pending_next & ~floor_mask(floor_up);
                        door_count_next = DOOR_LOAD;
                    end else if (!(|(pending & above_mask(floor_up)))) begin
                        state_next = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (floor_step && current_floor > 4'd1) begin
                    floor_next = floor_down;
                    if (|(pending & floor_mask(floor_down))) begin
                        state_next      = DOOR;
                        pending_next    = pending_next & ~floor_mask(floor_down);
                        door_count_next = DOOR_LOAD;
                    end else if (!(|(pending & below_mask(floor_down)))) begin
                        state_next = IDLE;
                    end
                end
            end
            DOOR: begin
                if (door_reload) begin
                    door_count_next = DOOR_LOAD;
                end else if (door_count == CW'(1)) begin
                    state_next      = IDLE;
                    door_count_next = '0;
                end else begin
                    door_count_next = door_count - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        move_up_next   = (state_next == MOVE_UP);
        move_down_next = (state_next == MOVE_DOWN);
        door_open_next = (state_next == DOOR);
    end
endmodule

// File: tb/tb_elevator_dispatch.sv
// Randomized scoreboard bench for elevator_dispatch against a floor-array
// reference model of the dispatch rules.
module tb_elevator_dispatch;
    localparam int NF  = 10;
    localparam int SEC = 10;
    localparam int DC  = 16;

    typedef struct {
        int          floor;
        bit          up;
        bit          down;
        bit          door;
        bit          fault;
        logic [NF-1:0] pend;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NF-1:0] call_request = '0;
    logic          secure = 1'b0;
    logic          maintenance_request = 1'b0;
    logic          floor_step = 1'b0;
    logic [3:0]    current_floor;
    logic          move_up, move_down, door_open, security_fault;
    logic [NF-1:0] pending;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    string m_mode;
    int    m_floor;
    bit    m_dir_up;
    int    m_timer;
    bit    m_pend[1:NF];
    bit    m_fault;

    elevator_dispatch #(.NUM_FLOORS(NF), .SECURE_FLOOR(SEC), .DOOR_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .call_request(call_request),
        .secure(secure),
        .maintenance_request(maintenance_request),
        .floor_step(floor_step),
        .current_floor(current_floor),
        .move_up(move_up),
        .move_down(move_down),
        .door_open(door_open),
        .pending(pending),
        .security_fault(security_fault)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic bit pend_above(input int f);
        for (int g = f + 1; g <= NF; g++) if (m_pend[g]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_below(input int f);
        for (int g = 1; g < f; g++) if (m_pend[g]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model_snapshot();
        exp_t e;
        e.floor = m_floor;
        e.up    = (m_mode == "up");
        e.down  = (m_mode == "down");
        e.door  = (m_mode == "door");
        e.fault = m_fault;
        for (int f = 1; f <= NF; f++) e.pend[f-1] = m_pend[f];
        return e;
    endfunction

    task automatic model_reset();
        m_mode = "idle";
        m_floor = 1;
        m_dir_up = 1'b1;
        m_timer = 0;
        m_fault = 1'b0;
        for (int f = 1; f <= NF; f++) m_pend[f] = 1'b0;
    endtask

    // Advance the model across one rising edge for the given inputs.
    task automatic model_step(input logic [NF-1:0] call, input bit sec, input bit maint, input bit stp);
        bit add[1:NF];
        bit reload;
        int clear_floor;
        reload = 1'b0;
        clear_floor = 0;
        m_fault = call[SEC-1] && !sec;
        for (int f = 1; f <= NF; f++) begin
            add[f] = 1'b0;
            if (call[f-1]) begin
                if (m_mode == "door" && f == m_floor) reload = 1'b1;
                else if (!(f == SEC && !sec)) add[f] = 1'b1;
            end
        end
        if (m_mode == "idle") begin
            if (m_pend[m_floor]) begin
                m_mode = "door"; m_timer = DC; clear_floor = m_floor;
            end else if (!maint) begin
                if (pend_above(m_floor) && (m_dir_up || !pend_below(m_floor))) begin
                    m_mode = "up"; m_dir_up = 1'b1;
                end else if (pend_below(m_floor)) begin
                    m_mode = "down"; m_dir_up = 1'b0;
                end
            end
        end else if (m_mode == "up") begin
            if (stp && m_floor < NF) begin
                m_floor++;
                if (m_pend[m_floor]) begin
                    m_mode = "door"; m_timer = DC; clear_floor = m_floor;
                end else if (!pend_above(m_floor)) m_mode = "idle";
            end
        end else if (m_mode == "down") begin
            if (stp && m_floor > 1) begin
                m_floor--;
                if (m_pend[m_floor]) begin
                    m_mode = "door"; m_timer = DC; clear_floor = m_floor;
                end else if (!pend_below(m_floor)) m_mode = "idle";
            end
        end else begin
            if (reload) m_timer = DC;
            else if (m_timer == 1) begin m_mode = "idle"; m_timer = 0; end
            else m_timer--;
        end
        for (int f = 1; f <= NF; f++) if (add[f]) m_pend[f] = 1'b1;
        if (clear_floor != 0) m_pend[clear_floor] = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [NF-1:0] call, input bit sec, input bit maint, input bit stp);
        @(negedge clk);
        #1;
        reset = 1'b0;
        call_request = call;
        secure = sec;
        maintenance_request = maint;
        floor_step = stp;
        model_step(call, sec, maint, stp);
        exp_q.push_back(model_snapshot());
    endtask

    task automatic idle_cycles(input int n, input bit maint);
        for (int i = 0; i < n; i++) apply_stimulus('0, 1'b0, maint, 1'b0);
    endtask

    task automatic step_floors(input int n, input bit maint);
        for (int i = 0; i < n; i++) begin
            apply_stimulus('0, 1'b0, maint, 1'b1);
            apply_stimulus('0, 1'b0, maint, 1'b0);
        end
    endtask

    // Reset is asserted mid-cycle so its effect is visible before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        call_request = '0;
        secure = 1'b0;
        maintenance_request = 1'b0;
        floor_step = 1'b0;
        model_reset();
        #1;
        check_output("async_floor", int'(current_floor), 1);
        check_output("async_move_up", int'(move_up), 0);
        check_output("async_move_down", int'(move_down), 0);
        check_output("async_door", int'(door_open), 0);
        check_output("async_pending", int'(pending), 0);
        check_output("async_fault", int'(security_fault), 0);
        exp_q.push_back(model_snapshot());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("floor", int'(current_floor), e.floor);
                check_output("move_up", int'(move_up), int'(e.up));
                check_output("move_down", int'(move_down), int'(e.down));
                check_output("door_open", int'(door_open), int'(e.door));
                check_output("pending", int'(pending), int'(e.pend));
                check_output("security_fault", int'(security_fault), int'(e.fault));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL timeout: bench did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        bit maint;
        logic [NF-1:0] call;
        do_reset();
        idle_cycles(2, 1'b0);
        apply_stimulus(10'h010, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        step_floors(4, 1'b0);
        idle_cycles(18, 1'b0);
        apply_stimulus(10'h042, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        step_floors(2, 1'b0);
        idle_cycles(18, 1'b0);
        step_floors(5, 1'b0);
        idle_cycles(18, 1'b0);
        apply_stimulus(10'h200, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);
        apply_stimulus(10'h200, 1'b1, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        step_floors(8, 1'b0);
        idle_cycles(18, 1'b0);
        apply_stimulus(10'h004, 1'b0, 1'b1, 1'b0);
        idle_cycles(5, 1'b1);
        idle_cycles(2, 1'b0);
        step_floors(3, 1'b0);
        step_floors(4, 1'b1);
        idle_cycles(13, 1'b0);
        apply_stimulus(10'h004, 1'b0, 1'b0, 1'b0);
        idle_cycles(20, 1'b0);
        apply_stimulus(10'h100, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        step_floors(6, 1'b0);
        idle_cycles(18, 1'b0);
        apply_stimulus(10'h0F0, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        do_reset();
        idle_cycles(3, 1'b0);

        maint = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            call = '0;
            if ($urandom_range(0, 5) == 0) call[$urandom_range(0, NF - 1)] = 1'b1;
            if ($urandom_range(0, 39) == 0) maint = ~maint;
            apply_stimulus(call, 1'($urandom_range(0, 1)), maint, 1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        check_output("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
